// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared encodings for the instruction fetch sequencer and the instruction register.
package instruction_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_FETCH_LO = 2'b01,
    S_FETCH_HI = 2'b10,
    S_DONE     = 2'b11
  } fetch_state_t;

  // IR LH select codes
  localparam logic IR_LOW  = 1'b0;
  localparam logic IR_HIGH = 1'b1;

endpackage

// File: rtl/instruction_fetch_sequencer_pc.sv
// Program counter: synchronous reset to RESET_PC, load has priority over increment.
module pc_register #(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_din,
  output logic [ADDR_W-1:0] o_q
);

  logic [ADDR_W-1:0] r_pc;

  // Increment wraps naturally modulo 2^ADDR_W
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_din;
    else if (i_inc)  r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  end

  assign o_q = r_pc;

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Two-cycle byte fetch sequencer: low byte then high byte into the 16-bit IR.
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stall,
  input  logic              i_pc_load,
  input  logic [ADDR_W-1:0] i_pc_in,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_read,
  output logic              o_ir_write,
  output logic              o_ir_lh,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic              o_busy,
  output logic              o_instr_valid
);

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic              w_pc_load;
  logic              w_pc_inc;
  logic [ADDR_W-1:0] w_pc;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk  (i_clock),
    .i_rst  (i_reset),
    .i_load (w_pc_load),
    .i_inc  (w_pc_inc),
    .i_din  (i_pc_in),
    .o_q    (w_pc)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_pc_load     = 1'b0;
    w_pc_inc      = 1'b0;
    o_mem_read    = 1'b0;
    o_ir_write    = 1'b0;
    o_ir_lh       = IR_LOW;
    o_busy        = 1'b0;
    o_instr_valid = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        // PCLoad lands at the same edge as Start, so the fetch uses the new PC
        o_instr_valid = (r_state == S_DONE);
        w_pc_load     = i_pc_load;
        if (i_start) w_next = S_FETCH_LO;
      end
      S_FETCH_LO: begin
        o_mem_read = 1'b1;
        o_busy     = 1'b1;
        if (!i_stall) begin
          o_ir_write = 1'b1;
          w_pc_inc   = 1'b1;
          w_next     = S_FETCH_HI;
        end
      end
      S_FETCH_HI: begin
        o_mem_read = 1'b1;
        o_busy     = 1'b1;
        if (!i_stall) begin
          o_ir_write = 1'b1;
          o_ir_lh    = IR_HIGH;
          w_pc_inc   = 1'b1;
          w_next     = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_mem_addr = w_pc;
  assign o_pc_out   = w_pc;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench: byte memory and IR model around the fetch sequencer.
module tb_instruction_fetch_sequencer;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset, start, stall, pc_load;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] mem_addr, pc_out;
  logic              mem_read, ir_write, ir_lh, busy, instr_valid;

  logic [7:0]  mem [0:65535];
  logic [15:0] ir;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_stall       (stall),
    .i_pc_load     (pc_load),
    .i_pc_in       (pc_in),
    .o_mem_addr    (mem_addr),
    .o_mem_read    (mem_read),
    .o_ir_write    (ir_write),
    .o_ir_lh       (ir_lh),
    .o_pc_out      (pc_out),
    .o_busy        (busy),
    .o_instr_valid (instr_valid)
  );

  // Downstream IR: captures the combinational memory byte at the edge
  always @(posedge clk) begin
    if (ir_write) begin
      if (ir_lh) ir[15:8] <= mem[mem_addr];
      else       ir[7:0]  <= mem[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; stall = 0; pc_load = 0; pc_in = '0;
    step(); step();
    reset = 0;
    tests++; if (pc_out !== 16'h0000) begin fails++; $display("FAIL reset_pc got=%h exp=0000", pc_out); end
    tests++; if ({ir_write, instr_valid, busy, mem_read} !== 4'b0000) begin fails++; $display("FAIL reset_outs got=%b exp=0000", {ir_write, instr_valid, busy, mem_read}); end
    step();
    tests++; if ({busy, instr_valid, pc_out} !== {2'b00, 16'h0000}) begin fails++; $display("FAIL reset_idle_hold busy/valid/pc got=%b%b/%h", busy, instr_valid, pc_out); end
  endtask

  task automatic test_basic_fetch();
    pc_load = 1; pc_in = 16'h0040; start = 1;
    step();
    pc_load = 0; start = 0;
    tests++; if ({mem_addr, ir_write, ir_lh, busy, instr_valid} !== {16'h0040, 4'b1010}) begin fails++; $display("FAIL fetch_lo addr=%h wr=%b lh=%b busy=%b vld=%b exp 0040/1/0/1/0", mem_addr, ir_write, ir_lh, busy, instr_valid); end
    step();
    tests++; if ({mem_addr, ir_write, ir_lh, busy, instr_valid} !== {16'h0041, 4'b1110}) begin fails++; $display("FAIL fetch_hi addr=%h wr=%b lh=%b busy=%b vld=%b exp 0041/1/1/1/0", mem_addr, ir_write, ir_lh, busy, instr_valid); end
    step();
    tests++; if ({instr_valid, busy, ir_write, mem_read} !== 4'b1000) begin fails++; $display("FAIL fetch_done vld/busy/wr/rd got=%b exp=1000", {instr_valid, busy, ir_write, mem_read}); end
    tests++; if (ir !== 16'h1234) begin fails++; $display("FAIL fetch_ir got=%h exp=1234", ir); end
    tests++; if (pc_out !== 16'h0042) begin fails++; $display("FAIL fetch_pc got=%h exp=0042", pc_out); end
  endtask

  task automatic test_back_to_back();
    pc_load = 1; pc_in = 16'h0010; start = 1;
    step();
    pc_load = 0;
    tests++; if (mem_addr !== 16'h0010 || ir_lh !== 1'b0) begin fails++; $display("FAIL b2b_lo0 addr=%h lh=%b exp 0010/0", mem_addr, ir_lh); end
    step();
    tests++; if (mem_addr !== 16'h0011 || ir_lh !== 1'b1) begin fails++; $display("FAIL b2b_hi0 addr=%h lh=%b exp 0011/1", mem_addr, ir_lh); end
    step();
    tests++; if (instr_valid !== 1'b1 || ir !== 16'hBBAA) begin fails++; $display("FAIL b2b_done0 vld=%b ir=%h exp 1/BBAA", instr_valid, ir); end
    step();
    tests++; if (mem_addr !== 16'h0012 || busy !== 1'b1 || instr_valid !== 1'b0) begin fails++; $display("FAIL b2b_lo1 addr=%h busy=%b vld=%b exp 0012/1/0", mem_addr, busy, instr_valid); end
    step();
    tests++; if (mem_addr !== 16'h0013 || ir_lh !== 1'b1) begin fails++; $display("FAIL b2b_hi1 addr=%h lh=%b exp 0013/1", mem_addr, ir_lh); end
    start = 0;
    step();
    tests++; if (instr_valid !== 1'b1 || ir !== 16'hDDCC) begin fails++; $display("FAIL b2b_done1 vld=%b ir=%h exp 1/DDCC", instr_valid, ir); end
    step();
    tests++; if (instr_valid !== 1'b1 || pc_out !== 16'h0014) begin fails++; $display("FAIL b2b_hold vld=%b pc=%h exp 1/0014", instr_valid, pc_out); end
  endtask

  task automatic test_stall();
    pc_load = 1; pc_in = 16'h0040; start = 1;
    step();
    pc_load = 0; start = 0;
    step();
    stall = 1; #1;
    tests++; if ({ir_write, ir_lh, mem_read} !== 3'b001 || mem_addr !== 16'h0041) begin fails++; $display("FAIL stall_comb wr=%b lh=%b rd=%b addr=%h exp 0/0/1/0041", ir_write, ir_lh, mem_read, mem_addr); end
    step();
    tests++; if (mem_addr !== 16'h0041 || ir_write !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL stall_c1 addr=%h wr=%b vld=%b exp 0041/0/0", mem_addr, ir_write, instr_valid); end
    step();
    tests++; if (mem_addr !== 16'h0041 || busy !== 1'b1 || instr_valid !== 1'b0) begin fails++; $display("FAIL stall_c2 addr=%h busy=%b vld=%b exp 0041/1/0", mem_addr, busy, instr_valid); end
    stall = 0; #1;
    tests++; if (ir_write !== 1'b1 || ir_lh !== 1'b1) begin fails++; $display("FAIL stall_release wr=%b lh=%b exp 1/1", ir_write, ir_lh); end
    step();
    tests++; if (instr_valid !== 1'b1 || ir !== 16'h1234 || pc_out !== 16'h0042) begin fails++; $display("FAIL stall_done vld=%b ir=%h pc=%h exp 1/1234/0042", instr_valid, ir, pc_out); end
  endtask

  task automatic test_pcload_ignored();
    pc_load = 1; pc_in = 16'h0020; start = 1;
    step();
    start = 0; pc_in = 16'h0100;
    step();
    tests++; if (mem_addr !== 16'h0021) begin fails++; $display("FAIL pcload_busy addr=%h exp 0021", mem_addr); end
    step();
    tests++; if (instr_valid !== 1'b1 || ir !== 16'hABCD || pc_out !== 16'h0022) begin fails++; $display("FAIL pcload_done vld=%b ir=%h pc=%h exp 1/ABCD/0022", instr_valid, ir, pc_out); end
    step();
    pc_load = 0;
    tests++; if (pc_out !== 16'h0100 || instr_valid !== 1'b1) begin fails++; $display("FAIL pcload_in_done pc=%h vld=%b exp 0100/1", pc_out, instr_valid); end
  endtask

  task automatic test_wrap();
    pc_load = 1; pc_in = 16'hFFFF; start = 1;
    step();
    pc_load = 0; start = 0;
    tests++; if (mem_addr !== 16'hFFFF) begin fails++; $display("FAIL wrap_lo addr=%h exp FFFF", mem_addr); end
    step();
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL wrap_hi addr=%h exp 0000", mem_addr); end
    step();
    tests++; if (ir !== 16'h5678 || pc_out !== 16'h0001) begin fails++; $display("FAIL wrap_done ir=%h pc=%h exp 5678/0001", ir, pc_out); end
  endtask

  task automatic test_reset_mid_fetch();
    pc_load = 1; pc_in = 16'h0040; start = 1;
    step();
    pc_load = 0; start = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    tests++; if ({ir_write, busy, instr_valid, mem_read} !== 4'b0000 || pc_out !== 16'h0000) begin fails++; $display("FAIL rstmid wr/busy/vld/rd=%b pc=%h exp 0000/0000", {ir_write, busy, instr_valid, mem_read}, pc_out); end
    step();
    tests++; if (ir_write !== 1'b0 || busy !== 1'b0 || pc_out !== 16'h0000) begin fails++; $display("FAIL rstmid_after wr=%b busy=%b pc=%h exp 0/0/0000", ir_write, busy, pc_out); end
    stall = 1; start = 1;
    step();
    stall = 0; start = 0;
    tests++; if (mem_addr !== 16'h0000 || ir_write !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL idle_stall_start addr=%h wr=%b busy=%b exp 0000/0/1", mem_addr, ir_write, busy); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
    mem[16'h0010] = 8'hAA; mem[16'h0011] = 8'hBB;
    mem[16'h0012] = 8'hCC; mem[16'h0013] = 8'hDD;
    mem[16'h0020] = 8'hCD; mem[16'h0021] = 8'hAB;
    mem[16'hFFFF] = 8'h78; mem[16'h0000] = 8'h56;
    ir = 16'h0000;
    reset = 1; start = 0; stall = 0; pc_load = 0; pc_in = '0;
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_stall();
    test_pcload_ignored();
    test_wrap();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
